// File: rtl/lc3_memory_interface.sv
// rtl/lc3_memory_interface.sv - LC-3 MAR/MDR bus receiver with memory handshake and keyboard/display registers
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   Bus               shared 16-bit datapath bus (source for MAR/MDR loads)
//   ldMAR, ldMDR      register load strobes from the control FSM
//   MIO_EN, R_W       access request and direction (1 = write)
//   MDROut, R         MDR contents and one-cycle access-complete pulse
//   mem_*             request/ready handshake to external memory
//   kb_data, kb_valid keyboard character input
//   disp_*            display character output with valid/ready
module lc3_memory_interface (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Bus,
    input  logic        ldMAR,
    input  logic        ldMDR,
    input  logic        MIO_EN,
    input  logic        R_W,
    output logic [15:0] MDROut,
    output logic        R,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    input  logic [7:0]  kb_data,
    input  logic        kb_valid,
    output logic [7:0]  disp_data,
    output logic        disp_valid,
    input  logic        disp_ready
);

    typedef enum logic [1:0] {IDLE, MEM_WAIT, DONE} state_t;

    state_t      state;
    logic [15:0] mar;
    logic [15:0] read_hold;
    logic        rd_access;
    logic        kb_ready;
    logic [7:0]  kbdr;

    logic        mmio_hit;
    logic        start;
    logic        kb_clear;
    logic        ddr_write;
    logic [15:0] mmio_value;

    // xFE00-xFE07 share the upper 13 address bits
    assign mmio_hit  = (mar[15:3] == 13'h1FC0);
    assign start     = (state == IDLE) && MIO_EN;
    assign kb_clear  = start && mmio_hit && !R_W && (mar[2:0] == 3'd2);
    assign ddr_write = start && mmio_hit &&  R_W && (mar[2:0] == 3'd6);

    always_comb begin
        mmio_value = 16'h0000;
        case (mar[2:0])
            3'd0:    mmio_value = {kb_ready, 15'b0};
            3'd2:    mmio_value = {8'h00, kbdr};
            3'd4:    mmio_value = {~disp_valid, 15'b0};
            default: mmio_value = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mar        <= 16'h0000;
            MDROut     <= 16'h0000;
            read_hold  <= 16'h0000;
            rd_access  <= 1'b0;
            R          <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 16'h0000;
            kb_ready   <= 1'b0;
            kbdr       <= 8'h00;
            disp_valid <= 1'b0;
            disp_data  <= 8'h00;
        end else begin
            if (ldMAR)
                mar <= Bus;

            // While an access is in flight MDR only takes the read result,
            // and only in the completion cycle of a read.
            if (ldMDR) begin
                if (!MIO_EN)
                    MDROut <= Bus;
                else if (R && rd_access)
                    MDROut <= read_hold;
            end

            case (state)
                IDLE: begin
                    if (MIO_EN) begin
                        rd_access <= !R_W;
                        if (mmio_hit) begin
                            if (!R_W)
                                read_hold <= mmio_value;
                            R     <= 1'b1;
                            state <= DONE;
                        end else begin
                            mem_addr  <= mar;
                            mem_wdata <= MDROut;
                            mem_we    <= R_W;
                            mem_req   <= 1'b1;
                            state     <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        if (!mem_we)
                            read_hold <= mem_rdata;
                        mem_req <= 1'b0;
                        R       <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    R     <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    R     <= 1'b0;
                    state <= IDLE;
                end
            endcase

            // A KBDR read frees the slot in the same cycle, so a coincident
            // keystroke is accepted while the read returns the old character.
            if (kb_valid && (!kb_ready || kb_clear)) begin
                kbdr     <= kb_data;
                kb_ready <= 1'b1;
            end else if (kb_clear) begin
                kb_ready <= 1'b0;
            end

            // A new DDR write takes precedence over the consumer's handshake.
            if (ddr_write) begin
                disp_data  <= MDROut[7:0];
                disp_valid <= 1'b1;
            end else if (disp_valid && disp_ready) begin
                disp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/lc3_memory_interface.md
# lc3_memory_interface

Bus-side receiver for the LC-3 datapath: captures the shared 16-bit bus into MAR and MDR and runs memory/device accesses requested by the control FSM. Ordinary addresses go out on a request/ready handshake to an external memory. xFE00–xFE06 is decoded to the keyboard and display device registers. MDROut feeds back into the bus driver, and R reports access completion to the control FSM.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- Bus  in  16  shared datapath bus
- ldMAR  in  1  load MAR from Bus
- ldMDR  in  1  load MDR (source chosen by MIO_EN)
- MIO_EN  in  1  request a memory/device access
- R_W  in  1  1 = write, 0 = read (sampled with MIO_EN)
- MDROut  out  16  MDR contents
- R  out  1  access complete, one-cycle pulse
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_ready  in  1  memory completion
- kb_data  in  8  keyboard character
- kb_valid  in  1  keyboard character strobe
- disp_data  out  8  display character
- disp_valid  out  1  display character pending
- disp_ready  in  1  display consumed character

## Operation
- **MAR:**
  - Loads Bus when ldMAR=1, in any state.
  - mem_addr and mem_wdata are latched at access start, so MAR/MDR changes mid-access are harmless.
- **MDR load priority:**
  - ldMDR=1 and MIO_EN=0: load Bus.
  - ldMDR=1, MIO_EN=1, R=1, read access: load the read-hold register.
  - ldMDR=1, MIO_EN=1, R=0: no change.
- **FSM states:** IDLE, MEM_WAIT, DONE.
- **IDLE:**
  - MIO_EN=1 with MAR in xFE00–xFE07 → MMIO access, go to DONE.
  - MIO_EN=1 with any other MAR value → latch MAR into mem_addr, latch MDR into mem_wdata, latch R_W into mem_we, go to MEM_WAIT.
- **MEM_WAIT:**
  - mem_req=1, with mem_addr, mem_we and mem_wdata held stable.
  - On mem_ready=1: on a read, capture mem_rdata into the read-hold register; go to DONE.
  - No timeout.
- **DONE:**
  - R=1 for exactly one cycle, then IDLE unconditionally.
  - If MIO_EN is still high in the following IDLE cycle, a new access starts.
- **MMIO reads** (value captured into read-hold on the IDLE→DONE edge):
  - xFE00 KBSR = {kb_ready, 15'b0}
  - xFE02 KBDR = {8'b0, kbdr}; the read clears kb_ready.
  - xFE04 DSR = {~disp_valid, 15'b0}
  - xFE06 DDR and odd addresses xFE01–xFE07 read as 0.
- **MMIO writes:**
  - Write to xFE06: disp_data <= MDR[7:0] and disp_valid <= 1. If disp_valid is already 1, the data is overwritten.
  - All other MMIO writes are ignored.
- **Keyboard:**
  - kb_valid with kb_ready=0 latches kb_data into kbdr and sets kb_ready.
  - kb_valid with kb_ready=1 is dropped.
  - kb_valid in the same cycle as a KBDR-read clear is accepted: new data latched, kb_ready=1. The read returns the old data.
- **Display:**
  - disp_valid clears on the cycle after disp_valid=1 and disp_ready=1.
  - A DDR write in the same cycle wins: disp_valid stays 1 with the new data.

## Timing
- **Reset values:**
  - MAR=0, MDR=0, read-hold=0.
  - State=IDLE, R=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - kb_ready=0, kbdr=0, disp_valid=0, disp_data=0.
- **Memory access latency:**
  - MIO_EN seen at cycle 0.
  - mem_req from cycle 1.
  - mem_ready at cycle k≥1 gives R=1 at cycle k+1.
  - Minimum is R at cycle 2.
- **MMIO latency:** R=1 at cycle 1; mem_req is never asserted.
- **Register outputs:** MDROut, R and all mem_*/disp_* outputs are registered.
- **Memory protocol:**
  - mem_ready is sampled only in MEM_WAIT and is ignored elsewhere.
  - The memory must hold mem_rdata valid in the mem_ready cycle.
- **Reset mid-access:** mem_req drops on the next edge. The memory must tolerate an abandoned request.

## Test plan
- **Memory read:** reset; Bus=x3000 with ldMAR; MIO_EN=1, R_W=0; memory returns x1234 with mem_ready 2 cycles after mem_req → mem_addr=x3000, mem_we=0, R pulses once; ldMDR with R gives MDROut=x1234.
- **Memory write:** MDR loaded from Bus=xBEEF, MAR=x4000, MIO_EN=1, R_W=1, mem_ready in the first request cycle → mem_we=1, mem_wdata=xBEEF, R at cycle 2.
- **Keyboard:** kb_valid with kb_data=x41 → KBSR read returns x8000; KBDR read returns x0041; next KBSR read returns x0000. A second kb_valid before the KBDR read is dropped.
- **Display:** DSR reads x8000; write DDR with MDR=x0048 → disp_valid=1, disp_data=x48; DSR reads x0000; disp_ready → DSR reads x8000.
- **Reset mid-access:** assert reset during MEM_WAIT → next cycle mem_req=0, R=0, MDROut=0. A following memory read completes normally.
- **Back-to-back and no-load cases:** MIO_EN held through DONE starts a second access; ldMDR with MIO_EN=1 and R=0 leaves MDR unchanged.
